// File: rtl/md_unit_if.sv
// Handshake/bus bundle between the EX-stage controller and the multiply/divide unit.
// Latency: none (wires only); hi/lo/busy are registered inside md_unit.
// Backpressure: busy tells the controller to hold further md issue.
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic        cancel;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    // Controller / pipeline side drives the request fields.
    modport master (
        output start, md_op, cancel, rs_val, rt_val,
        input  busy, hi, lo
    );

    // Multiply/divide unit side.
    modport slave (
        input  start, md_op, cancel, rs_val, rt_val,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// MIPS EX-stage multiply/divide unit owning HI/LO; MULT/MULTU/DIV/DIVU multi-cycle, MTHI/MTLO single-cycle.
// Latency: busy high MUL_CYCLES or DIV_CYCLES cycles; HI/LO visible the cycle busy falls; MTxx next cycle.
// Backpressure: busy blocks new accepts and MTxx; requests arriving while busy are dropped, never queued.
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic     clk,
    input  logic     rst_n,
    md_unit_if.slave md
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic             busy_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [63:0]      shadow;      // {hi,lo} result waiting for the commit edge
    logic             shadow_wr;   // cleared for divide-by-zero so HI/LO keep old values

    logic             is_mul;
    logic             is_div;
    logic             accept;
    logic [63:0]      result;
    logic             result_wr;

    assign is_mul = (md.md_op == OP_MULT) || (md.md_op == OP_MULTU);
    assign is_div = (md.md_op == OP_DIV)  || (md.md_op == OP_DIVU);
    assign accept = md.start && !md.cancel && !busy_q && (is_mul || is_div);

    // Full result computed in the accept cycle; the countdown only models issue timing.
    always_comb begin
        logic signed [63:0] prod_s;
        logic        [63:0] prod_u;
        logic               sdiv;
        logic        [31:0] num;
        logic        [31:0] den;
        logic        [31:0] quo;
        logic        [31:0] rem;
        prod_s    = $signed({{32{md.rs_val[31]}}, md.rs_val}) *
                    $signed({{32{md.rt_val[31]}}, md.rt_val});
        prod_u    = {32'd0, md.rs_val} * {32'd0, md.rt_val};
        sdiv      = (md.md_op == OP_DIV);
        // Signed divide works on magnitudes; 0x80000000 has no positive form but its
        // unsigned magnitude is still correct, which yields 0x80000000 / -1 = 0x80000000.
        num       = (sdiv && md.rs_val[31]) ? (32'd0 - md.rs_val) : md.rs_val;
        den       = (sdiv && md.rt_val[31]) ? (32'd0 - md.rt_val) : md.rt_val;
        // Substitute a harmless divisor for zero; that result is never written.
        if (den == 32'd0) begin
            den = 32'd1;
        end
        quo       = num / den;
        rem       = num % den;
        if (sdiv && (md.rs_val[31] ^ md.rt_val[31])) begin
            quo = 32'd0 - quo;
        end
        if (sdiv && md.rs_val[31]) begin
            rem = 32'd0 - rem;
        end
        result    = {rem, quo};
        result_wr = 1'b1;
        if (md.md_op == OP_MULT) begin
            result = prod_s;
        end else if (md.md_op == OP_MULTU) begin
            result = prod_u;
        end else if (md.rt_val == 32'd0) begin
            result_wr = 1'b0;
        end
    end

    // Busy countdown, commit of the shadow result, and MTHI/MTLO writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            cnt       <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            shadow    <= 64'd0;
            shadow_wr <= 1'b0;
        end else if (busy_q) begin
            if (cnt == CNT_W'(1)) begin
                busy_q <= 1'b0;
                cnt    <= '0;
                if (shadow_wr) begin
                    hi_q <= shadow[63:32];
                    lo_q <= shadow[31:0];
                end
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end else if (accept) begin
            busy_q    <= 1'b1;
            cnt       <= is_mul ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
            shadow    <= result;
            shadow_wr <= result_wr;
        end else if (!md.cancel && md.md_op == OP_MTHI) begin
            hi_q <= md.rs_val;
        end else if (!md.cancel && md.md_op == OP_MTLO) begin
            lo_q <= md.rs_val;
        end
    end

    assign md.busy = busy_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule
